// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer for a 128 x 32 synchronous data memory.
// Each access runs IDLE -> ISSUE -> RESP; clear/hold keep the memory output stable between accesses.
module data_mem_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_data,
  output logic [31:0] a_q,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_data,
  output logic [31:0] b_q,
  output logic        b_ack,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_data,
  output logic        mem_clear,
  output logic        mem_hold,
  input  logic [31:0] mem_q,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ISSUE, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic                grant;
  logic                win_d, win_q, last_q;
  logic                lat_we_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_data_q;

  // Upper address bits alias modulo 128 and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{a_addr[DATA_W-1:ADDR_W], b_addr[DATA_W-1:ADDR_W]};

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    win_d     = ID_A;
    mem_clear = 1'b0;
    mem_hold  = 1'b0;
    mem_we    = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_clear = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_IDLE: begin
        mem_hold = 1'b1;
        if (a_req || b_req) begin
          grant   = 1'b1;
          state_d = ST_ISSUE;
          // On a tie, round-robin favours whoever was not served last.
          if (a_req && b_req) win_d = ROUND_ROBIN ? ~last_q : ID_A;
          else                win_d = b_req ? ID_B : ID_A;
        end
      end
      ST_ISSUE: begin
        mem_we  = lat_we_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        mem_hold = 1'b1;
        a_ack    = (win_q == ID_A);
        b_ack    = (win_q == ID_B);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      win_q      <= ID_A;
      last_q     <= ID_B;
      lat_we_q   <= 1'b0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        win_q      <= win_d;
        lat_we_q   <= win_d ? b_we : a_we;
        lat_addr_q <= win_d ? b_addr[ADDR_W-1:0] : a_addr[ADDR_W-1:0];
        lat_data_q <= win_d ? b_data : a_data;
      end
      if (state_q == ST_RESP) last_q <= win_q;
    end
  end

  assign mem_addr = {{(DATA_W-ADDR_W){1'b0}}, lat_addr_q};
  assign mem_data = lat_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign a_q      = a_ack ? mem_q : '0;
  assign b_q      = b_ack ? mem_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: round-robin and fixed-priority instances share stimulus,
// each with its own memory model, checked every cycle against a transaction-level model.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [31:0] a_addr = '0, a_data = '0, b_addr = '0, b_data = '0;

  logic [1:0]        a_ack_w, b_ack_w, mwe, mclr, mhold, busy_w;
  logic [1:0][31:0]  a_q_w, b_q_w, maddr, mdata, mq;

  int total = 0;
  int bad   = 0;

  data_mem_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_q(a_q_w[0]), .a_ack(a_ack_w[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .b_q(b_q_w[0]), .b_ack(b_ack_w[0]),
    .mem_addr(maddr[0]), .mem_we(mwe[0]), .mem_data(mdata[0]), .mem_clear(mclr[0]),
    .mem_hold(mhold[0]), .mem_q(mq[0]), .busy(busy_w[0])
  );

  data_mem_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_q(a_q_w[1]), .a_ack(a_ack_w[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .b_q(b_q_w[1]), .b_ack(b_ack_w[1]),
    .mem_addr(maddr[1]), .mem_we(mwe[1]), .mem_data(mdata[1]), .mem_clear(mclr[1]),
    .mem_hold(mhold[1]), .mem_q(mq[1]), .busy(busy_w[1])
  );

  // Synchronous data memory with output clear and hold, one per instance.
  logic [31:0] mem [2][128];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mclr[i]) mq[i] <= '0;
      else if (!mhold[i]) begin
        if (mwe[i]) begin
          mem[i][maddr[i][6:0]] <= mdata[i];
          mq[i] <= mdata[i];
        end else begin
          mq[i] <= mem[i][maddr[i][6:0]];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  // Transaction-level model: an access is latched, then lasts two cycles (issue, respond).
  bit          m_init [2];
  int          m_left [2];
  bit          m_win [2], m_we [2], m_last [2];
  logic [6:0]  m_addr [2];
  logic [31:0] m_data [2], m_expq [2];
  logic [31:0] ref_mem [2][128];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      string p;
      bit    e_aack, e_back;
      p = (i == 0) ? "rr." : "fp.";
      if (reset) begin
        m_init[i] = 1'b1; m_left[i] = 0; m_last[i] = 1'b1;
        m_addr[i] = '0;   m_data[i] = '0; m_we[i] = 1'b0; m_win[i] = 1'b0;
      end
      e_aack = (m_left[i] == 1) && !m_win[i];
      e_back = (m_left[i] == 1) &&  m_win[i];
      chk({p, "busy"},     busy_w[i],  32'(m_init[i] || m_left[i] != 0));
      chk({p, "clear"},    mclr[i],    32'(m_init[i]));
      chk({p, "hold"},     mhold[i],   32'(!m_init[i] && m_left[i] != 2));
      chk({p, "mem_we"},   mwe[i],     32'(m_left[i] == 2 && m_we[i]));
      chk({p, "mem_addr"}, maddr[i],   {25'b0, m_addr[i]});
      chk({p, "mem_data"}, mdata[i],   m_data[i]);
      chk({p, "a_ack"},    a_ack_w[i], 32'(e_aack));
      chk({p, "b_ack"},    b_ack_w[i], 32'(e_back));
      chk({p, "a_q"},      a_q_w[i],   e_aack ? m_expq[i] : 32'h0);
      chk({p, "b_q"},      b_q_w[i],   e_back ? m_expq[i] : 32'h0);
      if (!reset) begin
        if (m_init[i]) m_init[i] = 1'b0;
        else if (m_left[i] == 2) begin
          if (m_we[i]) ref_mem[i][m_addr[i]] = m_data[i];
          m_left[i] = 1;
        end else if (m_left[i] == 1) begin
          m_last[i] = m_win[i];
          m_left[i] = 0;
        end else if (a_req || b_req) begin
          if (a_req && b_req) m_win[i] = (i == 0) ? !m_last[i] : 1'b0;
          else                m_win[i] = b_req;
          m_we[i]   = m_win[i] ? b_we : a_we;
          m_addr[i] = m_win[i] ? b_addr[6:0] : a_addr[6:0];
          m_data[i] = m_win[i] ? b_data : a_data;
          m_expq[i] = m_we[i] ? m_data[i] : ref_mem[i][m_addr[i]];
          m_left[i] = 2;
        end
      end
    end
  end

  // Single uncontended access from IDLE; ack is expected on the third sampled cycle.
  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] expq, input string nm);
    int n;
    bit got;
    logic [31:0] q;
    @(posedge clk); #1;
    if (port == 1'b0) begin a_req = 1'b1; a_we = we; a_addr = addr; a_data = data; end
    else              begin b_req = 1'b1; b_we = we; b_addr = addr; b_data = data; end
    n = 0; got = 1'b0; q = '0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      if (port == 1'b0 && a_ack_w[0]) begin got = 1'b1; q = a_q_w[0]; end
      if (port == 1'b1 && b_ack_w[0]) begin got = 1'b1; q = b_q_w[0]; end
    end
    chk({nm, ".ack_seen"}, 32'(got), 32'd1);
    chk({nm, ".q"}, q, expq);
    chk({nm, ".latency"}, n, 32'd3);
    @(posedge clk); #1;
    if (port == 1'b0) a_req = 1'b0; else b_req = 1'b0;
  endtask

  int          who [$];
  int          cyc [$];
  logic [31:0] qv  [$];

  initial begin
    int n, fp_a, fp_b;
    bit got;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("init.clear", mclr[0], 32'd1);
    chk("init.busy", busy_w[0], 32'd1);
    @(negedge clk);
    chk("idle.clear", mclr[0], 32'd0);
    chk("idle.busy", busy_w[0], 32'd0);
    chk("idle.hold", mhold[0], 32'd1);

    access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 32'hDEADBEEF, "a_wr5");
    access(1'b0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, "a_rd5");
    access(1'b0, 1'b0, 32'h0000_0085, 32'h0, 32'hDEADBEEF, "a_rd_alias");
    access(1'b1, 1'b1, 32'd1, 32'h11, 32'h11, "b_wr1");
    access(1'b1, 1'b1, 32'd2, 32'h22, 32'h22, "b_wr2");

    // Both requesters held high; round-robin alternates, fixed priority serves only A.
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
    fp_a = 0; fp_b = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (a_ack_w[0]) begin who.push_back(0); cyc.push_back(k); qv.push_back(a_q_w[0]); end
      if (b_ack_w[0]) begin who.push_back(1); cyc.push_back(k); qv.push_back(b_q_w[0]); end
      if (a_ack_w[1]) fp_a++;
      if (b_ack_w[1]) fp_b++;
    end
    chk("rr.ack_count", who.size(), 32'd8);
    if (who.size() > 0) chk("rr.first_cycle", cyc[0], 32'd3);
    for (int j = 0; j < who.size(); j++) begin
      chk("rr.order", who[j], 32'(j % 2));
      chk("rr.data", qv[j], (j % 2 == 1) ? 32'h22 : 32'h11);
      if (j > 0) chk("rr.spacing", cyc[j] - cyc[j-1], 32'd3);
    end
    chk("fp.a_count", fp_a, 32'd8);
    chk("fp.b_count", fp_b, 32'd0);

    n = 0; got = 1'b0;
    while (!got && n < 8) begin @(negedge clk); n++; if (a_ack_w[1]) got = 1'b1; end
    chk("fp.a_again", 32'(got), 32'd1);
    @(posedge clk); #1 a_req = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 8) begin @(negedge clk); n++; if (b_ack_w[1]) got = 1'b1; end
    chk("fp.b_after_a", n, 32'd3);
    chk("fp.b_q", b_q_w[1], 32'h22);
    @(posedge clk); #1 b_req = 1'b0;

    // B withdraws and scrambles its request after the latch edge.
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
    @(posedge clk); #1;
    b_req = 1'b0; b_addr = 32'd1; b_we = 1'b1; b_data = 32'hBAD0BAD0;
    n = 0; got = 1'b0;
    while (!got && n < 6) begin @(negedge clk); n++; if (b_ack_w[0]) got = 1'b1; end
    chk("wd.latency", n, 32'd2);
    chk("wd.q", b_q_w[0], 32'h22);
    b_we = 1'b0;
    repeat (4) @(negedge clk);

    // Reset lands while A's write is being acknowledged.
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd9; a_data = 32'h5A5A1234;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    chk("rst.ack_before", a_ack_w[0], 32'd1);
    reset = 1'b1; a_req = 1'b0; a_we = 1'b0;
    #1;
    chk("rst.ack_dropped", a_ack_w[0], 32'd0);
    chk("rst.clear", mclr[0], 32'd1);
    chk("rst.busy", busy_w[0], 32'd1);
    chk("rst.a_q", a_q_w[0], 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.init_clear", mclr[0], 32'd1);
    access(1'b0, 1'b0, 32'd9, 32'h0, 32'h5A5A1234, "a_rd9_after_rst");
    access(1'b1, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, "b_rd5");
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
